reu_sdram_resp: RTL

REU_SDRAM_RESP -- requirements
Module: reu_sdram_resp

---
 rtl/reu_sdram_resp.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/reu_sdram_resp.sv
// reu_sdram_resp: byte-wide SDRAM responder for a REU-style DMA sequencer.
// Runs the SDRAM power-up sequence and then serves at most one read or write per PHI2 cycle.
// Each access is slotted on C8M cycles counted from the synchronised PHI2 rising edge.
// A periodic AUTO REFRESH is issued at slot 6.
// Ports:
//   C8M, nRESET          clock and synchronous active-low reset
//   PHI2                 6502 phase-2, asynchronous to C8M
//   RAMRD/RAMWR, REUA    byte read/write request and 24-bit byte address
//   WRD / RAMRDD         write data / read data (held until the next completed read)
//   Ready, Overrun       init complete / sticky early-PHI2-edge flag
//   RCLK..RD             SDRAM bus (x16 part, only the lower byte lane used)
module reu_sdram_resp #(
    parameter int unsigned INIT_WAIT = 800,
    parameter int unsigned REF_DIV   = 4
) (
    input  logic        C8M,
    input  logic        nRESET,
    input  logic        PHI2,
    input  logic        RAMRD,
    input  logic        RAMWR,
    input  logic [23:0] REUA,
    input  logic [7:0]  WRD,
    output logic [7:0]  RAMRDD,
    output logic        Ready,
    output logic        Overrun,
    output logic        RCLK,
    output logic        nCS,
    output logic        nRAS,
    output logic        nCAS,
    output logic        nRWE,
    output logic        CKE,
    output logic [1:0]  RBA,
    output logic [12:0] RA,
    output logic        DQMH,
    output logic        DQML,
    inout  wire  [7:0]  RD
);

    localparam int unsigned REF_W = (REF_DIV > 1) ? $clog2(REF_DIV) : 1;

    // {nCS, nRAS, nCAS, nRWE}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    // Each NOP_x state is the gap following the command that entered it.
    localparam logic [2:0] ST_WAIT  = 3'd0;
    localparam logic [2:0] ST_NOP_A = 3'd1;
    localparam logic [2:0] ST_NOP_B = 3'd2;
    localparam logic [2:0] ST_NOP_C = 3'd3;
    localparam logic [2:0] ST_NOP_D = 3'd4;
    localparam logic [2:0] ST_RUN   = 3'd5;

    logic [2:0]       r_state;
    logic [15:0]      r_cnt;
    logic [3:0]       r_cmd;
    logic [1:0]       r_ba;
    logic [12:0]      r_ra;
    logic             r_cke;
    logic             r_ready;
    logic             r_overrun;
    logic [7:0]       r_rdd;
    logic             r_rd_oe;
    logic [7:0]       r_wdata;
    logic             r_phi_meta;
    logic             r_phi_sync;
    logic             r_phi_prev;
    logic [2:0]       r_slot;
    logic [REF_W-1:0] r_ref_cnt;
    logic             r_ref_pend;
    logic             r_acc_v;
    logic             r_acc_wr;
    logic [23:0]      r_addr;

    logic             w_phi_rise;
    logic [2:0]       w_slot_nxt;
    logic             w_slot0;
    logic             w_early;

    assign w_phi_rise = r_phi_sync & ~r_phi_prev;

    // Slot sequencing: an edge restarts the slot only once the previous access has reached
    // slot 6; earlier edges are dropped and flagged.
    always_comb begin
        w_slot_nxt = r_slot;
        w_slot0    = 1'b0;
        w_early    = 1'b0;
        if (r_state == ST_RUN) begin
            if (w_phi_rise && (r_slot >= 3'd6)) begin
                w_slot_nxt = 3'd0;
                w_slot0    = 1'b1;
            end else begin
                w_early = w_phi_rise;
                if (r_slot != 3'd7) begin
                    w_slot_nxt = r_slot + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge C8M) begin
        if (!nRESET) begin
            r_state    <= ST_WAIT;
            r_cnt      <= '0;
            r_cmd      <= CMD_NOP;
            r_ba       <= '0;
            r_ra       <= '0;
            r_cke      <= 1'b0;
            r_ready    <= 1'b0;
            r_overrun  <= 1'b0;
            r_rdd      <= 8'h00;
            r_rd_oe    <= 1'b0;
            r_wdata    <= 8'h00;
            r_phi_meta <= 1'b0;
            r_phi_sync <= 1'b0;
            r_phi_prev <= 1'b0;
            r_slot     <= 3'd7;
            r_ref_cnt  <= '0;
            r_ref_pend <= 1'b0;
            r_acc_v    <= 1'b0;
            r_acc_wr   <= 1'b0;
            r_addr     <= '0;
        end else begin
            r_phi_meta <= PHI2;
            r_phi_sync <= r_phi_meta;
            r_phi_prev <= r_phi_sync;
            // Bus defaults to NOP with address zeroed; commands override below.
            r_cmd      <= CMD_NOP;
            r_ba       <= '0;
            r_ra       <= '0;
            r_rd_oe    <= 1'b0;
            case (r_state)
                ST_WAIT: begin
                    if (r_cnt == 16'(INIT_WAIT)) begin
                        r_state <= ST_NOP_A;
                        r_cnt   <= '0;
                        r_cmd   <= CMD_PRE;
                        r_ra    <= 13'h0400;
                        r_cke   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_NOP_A, ST_NOP_B: begin
                    if (r_cnt == 16'd7) begin
                        r_state <= (r_state == ST_NOP_A) ? ST_NOP_B : ST_NOP_C;
                        r_cnt   <= '0;
                        r_cmd   <= CMD_REF;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_NOP_C: begin
                    if (r_cnt == 16'd7) begin
                        r_state <= ST_NOP_D;
                        r_cnt   <= '0;
                        r_cmd   <= CMD_LMR;
                        r_ra    <= 13'h0020;  // BL1, sequential, CAS latency 2
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_NOP_D: begin
                    if (r_cnt == 16'd2) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_RUN: begin
                    r_slot <= w_slot_nxt;
                    if (w_early) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_slot0) begin
                        if (r_ref_cnt == REF_W'(REF_DIV - 1)) begin
                            r_ref_cnt  <= '0;
                            r_ref_pend <= 1'b1;
                        end else begin
                            r_ref_cnt <= r_ref_cnt + REF_W'(1);
                        end
                    end
                    if (w_slot_nxt != r_slot) begin
                        case (w_slot_nxt)
                            3'd1: begin
                                r_acc_v <= RAMWR | RAMRD;
                                if (RAMWR | RAMRD) begin
                                    r_acc_wr <= RAMWR;
                                    r_addr   <= REUA;
                                    r_cmd    <= CMD_ACT;
                                    r_ba     <= REUA[23:22];
                                    r_ra     <= REUA[21:9];
                                end
                            end
                            3'd3: begin
                                if (r_acc_v) begin
                                    r_cmd <= r_acc_wr ? CMD_WR : CMD_RD;
                                    r_ba  <= r_addr[23:22];
                                    r_ra  <= {3'b001, 1'b0, r_addr[8:0]};  // A10 = auto-precharge
                                    if (r_acc_wr) begin
                                        r_rd_oe <= 1'b1;
                                        r_wdata <= WRD;
                                    end
                                end
                            end
                            3'd6: begin
                                // CL2 data from the slot-3 READ is valid on the bus now.
                                if (r_acc_v && !r_acc_wr) begin
                                    r_rdd <= RD;
                                end
                                if (r_ref_pend) begin
                                    r_cmd      <= CMD_REF;
                                    r_ref_pend <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: r_state <= ST_WAIT;
            endcase
        end
    end

    assign {nCS, nRAS, nCAS, nRWE} = r_cmd;
    assign RBA     = r_ba;
    assign RA      = r_ra;
    assign CKE     = r_cke;
    assign Ready   = r_ready;
    assign Overrun = r_overrun;
    assign RAMRDD  = r_rdd;
    assign RCLK    = ~C8M;
    assign DQML    = 1'b0;
    assign DQMH    = 1'b1;
    assign RD      = r_rd_oe ? r_wdata : 8'bzzzz_zzzz;

endmodule
